serial_burst_sender: RTL and testbench

SERIAL_BURST_SENDER -- requirements
Module: serial_burst_sender

---
 rtl/serial_burst_sender.sv | 91 +++++++++
 tb/tb_serial_burst_sender.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_burst_sender.sv
// serial_burst_sender: FIFO-fed serial packet transmitter with request-driven bursts
module serial_burst_sender #(
  parameter int DATA_W = 40,
  parameter int DEPTH = 4,
  parameter int GAP = 3,
  parameter int BURST_MAX = 2,
  parameter logic [DATA_W-1:0] REQ_PKT = 40'h0700000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic in_data_valid,
  input  logic req_mode,
  input  logic req_tick,
  output logic sout,
  output logic busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic data_loss
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DATA_W + GAP + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [DATA_W-1:0] sh;
  logic [CW-1:0] cnt;
  logic [BW-1:0] burst_cnt;
  logic req_pending;
  logic empty, full, gap_end, start_req, start_data, pop, push, drop;
  // Start decisions: a pending request wins in IDLE; data continues a burst at gap end
  always_comb begin
    empty = fifo_level == '0;
    full = fifo_level == (AW+1)'(DEPTH);
    gap_end = state == S_GAP && cnt == CW'(GAP - 1);
    start_req = state == S_IDLE && req_pending;
    start_data = (state == S_IDLE && !req_pending && !req_mode && !empty) ||
                 (gap_end && burst_cnt < BW'(BURST_MAX) && !empty);
    pop = start_data;
    push = in_data_valid && (!full || pop);
    drop = in_data_valid && full && !pop;
  end
  // FIFO storage; contents are invalidated on reset through the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_data;
  end
  // FIFO pointers, occupancy and drop pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      fifo_level <= '0;
      data_loss <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
      data_loss <= drop;
    end
  end
  // Framing FSM: start bit, MSB-first payload, then GAP idle cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      sout <= 1'b0;
      sh <= '0;
      cnt <= '0;
      burst_cnt <= '0;
      req_pending <= 1'b0;
    end else begin
      req_pending <= req_mode && (req_tick || (req_pending && !start_req));
      if (start_req || start_data) begin
        state <= S_SHIFT;
        sout <= 1'b1;
        cnt <= '0;
        sh <= start_req ? REQ_PKT : mem[rp];
        burst_cnt <= (start_data && state == S_GAP) ? burst_cnt + 1'b1 : BW'(1);
      end else if (state == S_SHIFT) begin
        state <= cnt == CW'(DATA_W) ? S_GAP : S_SHIFT;
        sout <= cnt == CW'(DATA_W) ? 1'b0 : sh[DATA_W-1];
        sh <= sh << 1;
        cnt <= cnt == CW'(DATA_W) ? '0 : cnt + 1'b1;
      end else if (state == S_GAP) begin
        state <= gap_end ? S_IDLE : S_GAP;
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign busy = state != S_IDLE;
endmodule

// File: tb/tb_serial_burst_sender.sv
// tb_serial_burst_sender: scoreboard bench for serial_burst_sender at default parameters
module tb_serial_burst_sender;
  localparam logic [39:0] REQ = 40'h0700000000;
  logic clk = 0, reset_n = 0, in_data_valid = 0, req_mode = 0, req_tick = 0;
  logic [39:0] in_data = '0;
  logic sout, busy, data_loss;
  logic [2:0] fifo_level;
  logic [39:0] exp_q [$];
  int starts [$];
  int cyc = 0, checks = 0, failures = 0, loss_cnt = 0;
  serial_burst_sender dut (.clk(clk), .reset_n(reset_n), .in_data(in_data),
    .in_data_valid(in_data_valid), .req_mode(req_mode), .req_tick(req_tick),
    .sout(sout), .busy(busy), .fifo_level(fifo_level), .data_loss(data_loss));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // monitor: deserialize each packet and compare against the scoreboard
  logic in_pkt = 0;
  int k = 0;
  logic [39:0] word = '0;
  always @(negedge clk) begin
    if (data_loss) loss_cnt++;
    if (!reset_n) in_pkt = 0;
    else if (!in_pkt) begin
      if (sout) begin
        in_pkt = 1;
        k = 0;
        starts.push_back(cyc);
      end
    end else begin
      word = {word[38:0], sout};
      k++;
      if (k == 40) begin
        in_pkt = 0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_packet: got %h expected none", word);
        end else check("packet", word, exp_q.pop_front());
      end
    end
  end
  task automatic wr(input logic [39:0] w);
    @(negedge clk);
    in_data = w;
    in_data_valid = 1;
  endtask
  task automatic wr_end();
    @(negedge clk);
    in_data_valid = 0;
  endtask
  task automatic tick();
    @(negedge clk);
    req_tick = 1;
    @(negedge clk);
    req_tick = 0;
  endtask
  initial begin
    int n, b, l;
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    check("rst_sout", sout, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_loss", data_loss, 0);
    // single word: start at next edge, 44 busy cycles
    wr(40'hD999999991);
    exp_q.push_back(40'hD999999991);
    wr_end();
    check("t1_not_yet", sout, 0);
    @(negedge clk);
    check("t1_start", sout, 1);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("t1_busy_cycles", n, 44);
    // three words: two-packet burst then new burst
    b = starts.size();
    wr(40'h1111111111); wr(40'h2222222222); wr(40'h3333333333); wr_end();
    exp_q.push_back(40'h1111111111); exp_q.push_back(40'h2222222222); exp_q.push_back(40'h3333333333);
    repeat (200) @(negedge clk);
    check("t2_packets", starts.size() - b, 3);
    if (starts.size() >= b + 3) begin
      check("t2_b2b", starts[b+1] - starts[b], 44);
      check("t2_newburst", starts[b+2] - starts[b+1], 45);
    end
    check("t2_loss", loss_cnt, 0);
    // request mode: data held until req_tick
    req_mode = 1;
    b = starts.size();
    wr(40'hAAAAAAAAAA); wr(40'hBBBBBBBBBB); wr_end();
    repeat (10) @(negedge clk);
    check("t3_held", starts.size() - b, 0);
    check("t3_level2", fifo_level, 2);
    exp_q.push_back(REQ); exp_q.push_back(40'hAAAAAAAAAA);
    tick();
    repeat (150) @(negedge clk);
    check("t3_burst1", starts.size() - b, 2);
    check("t3_level1", fifo_level, 1);
    check("t3_idle", busy, 0);
    exp_q.push_back(REQ); exp_q.push_back(40'hBBBBBBBBBB);
    tick();
    repeat (150) @(negedge clk);
    check("t3_burst2", starts.size() - b, 4);
    check("t3_level0", fifo_level, 0);
    // overflow while idle in request mode
    l = loss_cnt;
    b = starts.size();
    wr(40'hC000000000); wr(40'hC111111111); wr(40'hC222222222); wr(40'hC333333333);
    wr(40'hDEADBEEF00); wr_end();
    repeat (5) @(negedge clk);
    check("t4_loss_pulse", loss_cnt - l, 1);
    check("t4_level_full", fifo_level, 4);
    check("t4_no_tx", starts.size() - b, 0);
    exp_q.push_back(40'hC000000000); exp_q.push_back(40'hC111111111);
    exp_q.push_back(40'hC222222222); exp_q.push_back(40'hC333333333);
    @(negedge clk);
    req_mode = 0;
    repeat (250) @(negedge clk);
    check("t4_drained", fifo_level, 0);
    check("t4_packets", starts.size() - b, 4);
    // req_tick during a data packet
    req_mode = 1;
    b = starts.size();
    wr(40'hEEEEEEEEEE); wr_end();
    exp_q.push_back(REQ); exp_q.push_back(40'hEEEEEEEEEE); exp_q.push_back(REQ);
    tick();
    repeat (60) @(negedge clk);
    tick();
    repeat (150) @(negedge clk);
    check("t5_packets", starts.size() - b, 3);
    if (starts.size() >= b + 3) check("t5_req_after_idle", starts[b+2] - starts[b+1], 45);
    // reset mid-packet
    req_mode = 0;
    b = starts.size();
    wr(40'hF0F0F0F0F0); wr(40'h123456789A); wr_end();
    repeat (20) @(negedge clk);
    check("t6_level_before", fifo_level, 1);
    reset_n = 0;
    exp_q.delete();
    #1;
    check("t6_sout", sout, 0);
    check("t6_level", fifo_level, 0);
    check("t6_busy", busy, 0);
    @(negedge clk);
    reset_n = 1;
    repeat (100) @(negedge clk);
    check("t6_no_resume", starts.size() - b, 1);
    check("t6_idle", busy, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
